chip8_rom_loader: RTL
=====================

# chip8_rom_loader

Serial program loader sitting directly upstream of CPU memory port A. Receives a framed byte stream from the UART receiver and writes the payload into memory starting at 0x200. Holds the CPU halted while a load is in progress. When idle, it passes CPU port-A accesses straight through, so it is the single owner of the memory's port A.

## Interface

Parameters:

- LOAD_BASE, 12'h200: first memory address written.
- MAX_LEN, 3584: largest accepted payload length in bytes; 0x200 + 3584 = 0x1000.
- SYNC_BYTE, 8'hC8: frame start marker.
- TIMEOUT, 5_000_000: idle cycles allowed between bytes inside a frame.

Ports:

- clk, in, 1: single clock. All logic is on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- rx_valid, in, 1: one-cycle strobe marking rx_data as valid.
- rx_data, in, 8: received byte.
- cpu_en, in, 1: CPU port-A enable.
- cpu_write, in, 1: CPU port-A write.
- cpu_addr, in, 12: CPU port-A address.
- cpu_din, in, 8: CPU port-A write data.
- mem_en, out, 1: to memory a_en.
- mem_write, out, 1: to memory a_write.
- mem_addr, out, 12: to memory a_addr.
- mem_din, out, 8: to memory a_in.
- cpu_halt, out, 1: CPU must not advance while high.
- load_done, out, 1: one-cycle pulse when a frame is accepted.
- load_err, out, 1: sticky flag for a bad frame.

## Operation

- Frame format: SYNC_BYTE, LEN_H, LEN_L, LEN payload bytes, CSUM.
  - LEN is a 16-bit big-endian value.
  - CSUM is the 8-bit sum of the payload bytes, modulo 256.
- State IDLE:
  - Bytes other than SYNC_BYTE are discarded.
  - SYNC_BYTE moves to LEN_H and clears load_err, the byte index and the running sum.
- State LEN_H: the byte is stored as length[15:8]; move to LEN_L.
- State LEN_L: the byte is stored as length[7:0].
  - If the full length is 0 or greater than MAX_LEN: load_err=1, go to IDLE.
  - Otherwise go to DATA.
- State DATA: for each byte:
  - issue a write at LOAD_BASE+index;
  - add the byte to the 8-bit sum;
  - increment the index;
  - when index reaches length, go to CSUM.
- State CSUM:
  - If the byte equals the sum: pulse load_done and go to IDLE.
  - Otherwise set load_err=1 and go to IDLE.
  - Memory written before the failure is left as written.
- Timeout: in any state other than IDLE, a 23-bit counter increments each cycle without rx_valid and resets on rx_valid. When it reaches TIMEOUT: load_err=1, go to IDLE.
- cpu_halt = (state != IDLE) or load_err. A failed load keeps the CPU halted until a later frame succeeds.
- Port-A mux:
  - While cpu_halt=1, the mem_* outputs are driven from the loader write registers, and CPU inputs are ignored.
  - While cpu_halt=0, mem_* = cpu_* combinationally.
- Address arithmetic:
  - 12 bits, LOAD_BASE plus an index of at least 12 bits.
  - MAX_LEN guarantees the address never wraps past 0xFFF.
- rx_valid is never back-pressured. The loader accepts one byte per cycle at full rate.

## Timing

- Reset values: state=IDLE, cpu_halt=0, load_err=0, load_done=0, counters=0, loader write registers=0.
  - With cpu_halt=0 after reset, mem_* follow cpu_*, so the CPU runs the resident image.
- Write latency: a payload byte accepted in cycle N gives mem_en=mem_write=1 with its address and data in cycle N+1, for exactly one cycle.
- Back-to-back payload bytes give back-to-back writes.
- load_done pulses in the cycle after the CSUM byte is accepted.
- cpu_halt rises in the cycle after SYNC_BYTE is accepted.
- On success, cpu_halt falls in the same cycle load_done is high. The last payload write has already completed by then.
- Timeout is detected on the cycle where the counter equals TIMEOUT. load_err is visible in the next cycle.
- Reset mid-frame returns immediately to the reset values. The partial write is abandoned, and the CPU resumes passthrough.
- SYNC_BYTE received outside IDLE is treated as ordinary data (a length byte, payload or checksum).

## Structure

- Shared package chip8_pkg:
  - memory geometry constants: ADDR_W=12, DATA_W=8, PROG_BASE=12'h200;
  - state enum (IDLE, LEN_H, LEN_L, DATA, CSUM);
  - SYNC_BYTE.
- Sub-module chip8_loader_timeout: a loadable counter with clear and terminal-count output. It is reusable for the UART receiver.
- Port-A mux kept inline in chip8_rom_loader.

## Test plan

- Normal load: rx C8 00 03 AA BB CC 31 → writes at 0x200=AA, 0x201=BB, 0x202=CC, one cycle after each byte; load_done pulses once; cpu_halt returns to 0; load_err=0.
- Bad checksum: rx C8 00 01 55 00 → write at 0x200=55; load_err=1; cpu_halt stays 1; no load_done. A following valid frame clears both.
- Length limits:
  - LEN=0x0000 → load_err=1 with no writes.
  - LEN=0x0E01 → load_err=1 with no writes.
  - LEN=0x0E00 → last write at 0xFFF.
- Timeout: rx C8 00 02 11, then silence for TIMEOUT cycles → load_err=1, state IDLE; subsequent bytes other than C8 produce no writes.
- Passthrough and noise:
  - In IDLE, rx 00 FF 12 causes no halt.
  - CPU write 0x345=7E appears on mem_* in the same cycle.
  - During a load, CPU writes never reach mem_*.
- Reset mid-DATA: assert rst after 2 of 5 payload bytes → all outputs return to their reset values next cycle; no further writes.

Source files
------------

// File: rtl/chip8_pkg.sv
// chip8_pkg: shared CHIP-8 memory geometry, loader states and framing constants
package chip8_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] PROG_BASE = 12'h200;
  localparam logic [DATA_W-1:0] SYNC_BYTE = 8'hC8;
  typedef enum logic [2:0] {IDLE, LEN_H, LEN_L, DATA, CSUM} load_state_t;
endpackage

// File: rtl/chip8_loader_timeout.sv
// chip8_loader_timeout: loadable up-counter with clear and terminal-count flag
module chip8_loader_timeout #(
  parameter int W  = 23,
  parameter int TC = 5_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic         tc
);
  logic [W-1:0] count;
  always_ff @(posedge clk)
    count <= (rst || clr) ? '0 : ld ? ld_val : en ? count + W'(1) : count;
  assign tc = count == W'(TC);
endmodule

// File: rtl/chip8_rom_loader.sv
// chip8_rom_loader: framed serial program loader that owns CPU memory port A
module chip8_rom_loader #(
  parameter logic [chip8_pkg::ADDR_W-1:0] LOAD_BASE = chip8_pkg::PROG_BASE,
  parameter int                           MAX_LEN   = 3584,
  parameter logic [chip8_pkg::DATA_W-1:0] SYNC_BYTE = chip8_pkg::SYNC_BYTE,
  parameter int                           TIMEOUT   = 5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        cpu_en,
  input  logic        cpu_write,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic        mem_en,
  output logic        mem_write,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        cpu_halt,
  output logic        load_done,
  output logic        load_err
);
  chip8_pkg::load_state_t state, state_n;
  logic [15:0] len, idx, len_full;
  logic [7:0]  sum, wr_data;
  logic [11:0] wr_addr;
  logic        wr_en, done, err, idle, to_hit, wr_fire, err_set, done_set, len_bad;
  assign idle     = state == chip8_pkg::IDLE;
  assign len_full = {len[15:8], rx_data};
  assign len_bad  = len_full == 16'd0 || len_full > 16'(MAX_LEN);
  chip8_loader_timeout #(.W(23), .TC(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (idle || rx_valid),
    .en     (!idle),
    .ld     (1'b0),
    .ld_val (23'd0),
    .tc     (to_hit)
  );
  // Timeout wins over a byte arriving in the same cycle.
  always_comb begin
    state_n  = state;
    wr_fire  = 1'b0;
    err_set  = 1'b0;
    done_set = 1'b0;
    if (!idle && to_hit) begin
      state_n = chip8_pkg::IDLE;
      err_set = 1'b1;
    end else if (rx_valid) begin
      case (state)
        chip8_pkg::IDLE:  state_n = (rx_data == SYNC_BYTE) ? chip8_pkg::LEN_H : chip8_pkg::IDLE;
        chip8_pkg::LEN_H: state_n = chip8_pkg::LEN_L;
        chip8_pkg::LEN_L: begin
          state_n = len_bad ? chip8_pkg::IDLE : chip8_pkg::DATA;
          err_set = len_bad;
        end
        chip8_pkg::DATA: begin
          wr_fire = 1'b1;
          state_n = (idx + 16'd1 == len) ? chip8_pkg::CSUM : chip8_pkg::DATA;
        end
        chip8_pkg::CSUM: begin
          state_n  = chip8_pkg::IDLE;
          done_set = rx_data == sum;
          err_set  = rx_data != sum;
        end
        default: state_n = chip8_pkg::IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= chip8_pkg::IDLE;
      len     <= '0;
      idx     <= '0;
      sum     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_n;
      wr_en <= wr_fire;
      done  <= done_set;
      if (idle && rx_valid && rx_data == SYNC_BYTE) begin
        err <= 1'b0;
        idx <= '0;
        sum <= '0;
      end else if (err_set) begin
        err <= 1'b1;
      end
      if (rx_valid && state == chip8_pkg::LEN_H) len[15:8] <= rx_data;
      if (rx_valid && state == chip8_pkg::LEN_L) len[7:0] <= rx_data;
      if (wr_fire) begin
        wr_addr <= LOAD_BASE + idx[11:0];
        wr_data <= rx_data;
        sum     <= sum + rx_data;
        idx     <= idx + 16'd1;
      end
    end
  end
  // A failed load keeps the CPU parked so it never runs a half-written image.
  assign cpu_halt  = !idle || err;
  assign mem_en    = cpu_halt ? wr_en : cpu_en;
  assign mem_write = cpu_halt ? wr_en : cpu_write;
  assign mem_addr  = cpu_halt ? wr_addr : cpu_addr;
  assign mem_din   = cpu_halt ? wr_data : cpu_din;
  assign load_done = done;
  assign load_err  = err;
endmodule
